mux_nx1_seq: RTL and testbench
==============================

# mux_nx1_seq

Parametrised, registered N:1 channel multiplexer with a valid/ready output stage and an optional auto-scan sequencer. It generalises the fixed 8:1 single-bit mux to N channels of W bits each. In manual mode, software-style select requests are served. In scan mode, enabled channels are visited round-robin. It sits between banks of parallel sources and a single downstream consumer that may stall.

## Interface
Parameters:
- N, default 8: number of input channels; N ≥ 2.
- W, default 8: bits per channel.
- SW, default $clog2(N): select/channel-index width; derived, not overridden.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- inp, input, N*W: packed channels; channel k = inp[k*W +: W].
- sel, input, SW: manual-mode channel select.
- req, input, 1: manual-mode capture request.
- mode, input, 1: 0 = manual, 1 = auto-scan.
- ch_en, input, N: auto-scan channel enable mask.
- out, output, W: registered selected data.
- out_ch, output, SW: index of the channel held in out.
- out_last, output, 1: held beat is the highest-index enabled channel of the scan (auto only).
- out_valid, output, 1: output register holds a valid beat.
- out_ready, input, 1: consumer accepts the beat.
- sel_err, output, 1: one-cycle pulse when a manual capture had sel ≥ N.

## Operation
- Reset (async assert, sync release): out=0, out_ch=0, out_last=0, out_valid=0, sel_err=0, scan pointer ptr=0.
- Load condition: load = !out_valid || out_ready. All captures happen only on a clock edge with load=1.
- While out_valid=1 and out_ready=0, these hold stable and input changes are ignored:
  - out, out_ch, out_last and ptr.
- Manual mode (mode=0):
  - On load with req=1 and sel < N: out←channel sel, out_ch←sel, out_last←0, out_valid←1.
  - On load with req=1 and sel ≥ N (only possible when N is not a power of two): out←0, out_ch←sel, out_valid←1, sel_err pulses for 1 cycle.
  - On load with req=0: out_valid←0; out and out_ch hold their last values.
  - ptr is forced to 0 every cycle while mode=0.
- Auto-scan mode (mode=1): req and sel are ignored.
  - On load, search for the first k with ch_en[k]=1, starting at ptr, ascending, wrapping N-1→0.
  - If found: out←channel k, out_ch←k, out_valid←1, ptr←(k+1) mod N.
  - out_last←1 iff no enabled channel has an index above k.
  - If ch_en=0: out_valid←0 and ptr holds.
  - The search is combinational over one cycle, so any enable pattern gives a new beat every accepted cycle.
- Mode switch takes effect on the next load. The first auto beat after leaving manual starts its search at channel 0.
- Changes to ch_en are sampled only at load; a beat already held is never altered.
- sel_err is 0 in all other cycles.

## Timing
- Latency: 1 cycle. Data sampled on edge t appears on out after edge t.
- Throughput: 1 beat/cycle while out_ready=1.
- A transfer occurs on an edge where out_valid=1 and out_ready=1. The next beat loads on that same edge (no bubble).
- Simultaneous transfer and empty request (manual req=0, or auto ch_en=0): out_valid deasserts on that edge.
- Reset asserted mid-stall or mid-scan clears everything immediately. After release, auto scan restarts at channel 0.

## Test plan
- **Manual sweep.** N=8, W=8, inp channel k = 8'h10+k, mode=0, req=1, out_ready=1, sel 0..7 over consecutive cycles → out = 8'h10..8'h17 one cycle later, out_ch=sel, out_valid=1 throughout, out_last=0.
- **Stall hold.** Manual, sel=3 captured, then out_ready=0 for 4 cycles while sel and inp change → out=8'h13, out_ch=3 stable. On out_ready=1, the new sel is loaded on that edge.
- **Auto-scan with mask.** mode=1, ch_en=8'b1010_0110, out_ready=1 → out_ch sequence 1,2,5,7,1,2,… and out_last=1 only on ch 7 beats.
  - Stall 2 cycles on ch 5 → ch 5 held, then 7 follows.
- **Empty mask.** Auto, ch_en=0 → out_valid=0 after the current beat is accepted. Then ch_en=8'h08 → ch 3 repeated, with out_last=1 every beat.
- **Non-power-of-two.** N=5, sel=6, req=1 → out=0, out_ch=6, out_valid=1, sel_err high exactly 1 cycle. In auto mode, the wrap goes 4→0.
- **Reset mid-operation.** Auto scanning at ch 5 with out_valid=1 and out_ready=0; assert rst_n=0 between edges → all outputs 0 immediately. After release with ch_en=8'hFF, the first beat is ch 0.

Source files
------------

// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered N:1 channel mux with a valid/ready output stage.
// Manual mode serves select requests; auto mode scans enabled channels round-robin.
module mux_nx1_seq #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] inp,
  input  logic [SW-1:0]  sel,
  input  logic           req,
  input  logic           mode,
  input  logic [N-1:0]   ch_en,
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  localparam logic [SW:0]   N_LIM = (SW+1)'(N);
  localparam logic [SW-1:0] N_TOP = SW'(N - 1);

  logic [W-1:0]  out_r;
  logic [SW-1:0] out_ch_r;
  logic          out_last_r;
  logic          out_valid_r;
  logic          sel_err_r;
  logic [SW-1:0] ptr_r;

  logic          load_s;
  logic          sel_ok_s;
  logic [W-1:0]  man_data_s;
  logic [W-1:0]  scan_data_s;
  logic          scan_hit_s;
  logic [SW-1:0] scan_idx_s;
  logic [SW-1:0] cand_idx_s;
  logic [SW-1:0] top_idx_s;
  logic [SW-1:0] ptr_next_s;
  int            cand_s;

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus, input logic [SW-1:0] idx);
    logic [W-1:0] res;
    res = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      res = (idx == SW'(k)) ? bus[k*W +: W] : res;
    end
    return res;
  endfunction

  assign load_s      = ~out_valid_r | out_ready;
  assign sel_ok_s    = ({1'b0, sel} < N_LIM);
  assign man_data_s  = pick(inp, sel);
  assign scan_data_s = pick(inp, scan_idx_s);
  assign ptr_next_s  = (scan_idx_s == N_TOP) ? {SW{1'b0}} : scan_idx_s + SW'(1);

  // First enabled channel at or after ptr, wrapping past N-1 back to 0.
  always_comb begin
    scan_hit_s = 1'b0;
    scan_idx_s = {SW{1'b0}};
    cand_idx_s = {SW{1'b0}};
    cand_s     = 0;
    for (int i = 0; i < N; i++) begin
      cand_s     = int'(ptr_r) + i;
      cand_s     = (cand_s >= N) ? cand_s - N : cand_s;
      cand_idx_s = SW'(cand_s);
      scan_idx_s = (!scan_hit_s && ch_en[cand_idx_s]) ? cand_idx_s : scan_idx_s;
      scan_hit_s = scan_hit_s | ch_en[cand_idx_s];
    end
  end

  // Highest enabled index, used to flag the last beat of a scan pass.
  always_comb begin
    top_idx_s = {SW{1'b0}};
    for (int j = 0; j < N; j++) begin
      top_idx_s = ch_en[j] ? SW'(j) : top_idx_s;
    end
  end

  // Output register, scan pointer and error pulse; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {W{1'b0}};
      out_ch_r    <= {SW{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sel_err_r   <= 1'b0;
      ptr_r       <= {SW{1'b0}};
    end else begin
      sel_err_r <= 1'b0;
      if (load_s && !mode) begin
        if (req) begin
          out_r       <= sel_ok_s ? man_data_s : {W{1'b0}};
          out_ch_r    <= sel;
          out_last_r  <= 1'b0;
          out_valid_r <= 1'b1;
          sel_err_r   <= ~sel_ok_s;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
      if (load_s && mode) begin
        if (scan_hit_s) begin
          out_r       <= scan_data_s;
          out_ch_r    <= scan_idx_s;
          out_last_r  <= (scan_idx_s == top_idx_s);
          out_valid_r <= 1'b1;
          ptr_r       <= ptr_next_s;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
      if (!mode) begin
        ptr_r <= {SW{1'b0}};
      end
    end
  end

  assign out       = out_r;
  assign out_ch    = out_ch_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Bench for mux_nx1_seq: scoreboarded N=8 instance plus a directed N=5
// instance for out-of-range selects and the odd-size scan wrap.
module tb_mux_nx1_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] chan [8];
  logic [63:0] inp;
  logic [2:0] sel;
  logic       req;
  logic       mode;
  logic [7:0] ch_en;
  logic       out_ready;
  logic [7:0] out;
  logic [2:0] out_ch;
  logic       out_last;
  logic       out_valid;
  logic       sel_err;

  logic [7:0]  chan5 [5];
  logic [39:0] inp5;
  logic [2:0]  sel5;
  logic        req5;
  logic        mode5;
  logic [4:0]  ch_en5;
  logic        out_ready5;
  logic [7:0]  out5;
  logic [2:0]  out_ch5;
  logic        out_last5;
  logic        out_valid5;
  logic        sel_err5;

  assign inp  = {chan[7], chan[6], chan[5], chan[4], chan[3], chan[2], chan[1], chan[0]};
  assign inp5 = {chan5[4], chan5[3], chan5[2], chan5[1], chan5[0]};

  mux_nx1_seq #(.N(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .sel(sel), .req(req), .mode(mode),
    .ch_en(ch_en), .out(out), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_nx1_seq #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .inp(inp5), .sel(sel5), .req(req5), .mode(mode5),
    .ch_en(ch_en5), .out(out5), .out_ch(out_ch5), .out_last(out_last5),
    .out_valid(out_valid5), .out_ready(out_ready5), .sel_err(sel_err5)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] ch;
    logic       last;
  } beat_t;

  beat_t      sbq [$];
  bit         m_valid = 1'b0;
  logic [2:0] m_ptr   = 3'd0;
  int         n_total = 0;
  int         n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for the coming edge: retire accepted beat, queue new one.
  task automatic model_edge();
    beat_t      b;
    bit         ld;
    bit         found;
    logic [2:0] cand;
    logic [2:0] kk;
    ld = !m_valid || out_ready;
    if (m_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
    if (ld) begin
      if (!mode) begin
        if (req) begin
          b.d = chan[sel]; b.ch = sel; b.last = 1'b0;
          sbq.push_back(b);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end else begin
        found = 1'b0;
        kk    = 3'd0;
        for (int i = 0; i < 8; i++) begin
          cand = m_ptr + 3'(i);
          if (!found && ch_en[cand]) begin
            found = 1'b1;
            kk    = cand;
          end
        end
        if (found) begin
          b.d = chan[kk]; b.ch = kk;
          b.last = ((ch_en >> (int'(kk) + 1)) == 8'd0);
          sbq.push_back(b);
          m_valid = 1'b1;
          m_ptr   = kk + 3'd1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    if (!mode) m_ptr = 3'd0;
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_val({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check_val({tag, ".err"}, 32'(sel_err), 32'd0);
    if (m_valid && sbq.size() > 0) begin
      check_val({tag, ".data"}, 32'(out), 32'(sbq[0].d));
      check_val({tag, ".ch"}, 32'(out_ch), 32'(sbq[0].ch));
      check_val({tag, ".last"}, 32'(out_last), 32'(sbq[0].last));
    end
  endtask

  int exp_ch5 [4] = '{0, 4, 0, 4};

  initial begin
    rst_n = 1'b0; mode = 1'b0; req = 1'b0; sel = 3'd0; ch_en = 8'd0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) chan[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) chan5[k] = 8'h50 + 8'(k);
    sel5 = 3'd0; req5 = 1'b0; mode5 = 1'b0; ch_en5 = 5'd0; out_ready5 = 1'b1;

    #12;
    check_val("rst.out", 32'(out), 32'd0);
    check_val("rst.ch", 32'(out_ch), 32'd0);
    check_val("rst.last", 32'(out_last), 32'd0);
    check_val("rst.valid", 32'(out_valid), 32'd0);
    check_val("rst.err", 32'(sel_err), 32'd0);
    check_val("rst.valid5", 32'(out_valid5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 8; s++) begin
      sel = 3'(s); req = 1'b1;
      cyc("sweep");
    end

    sel = 3'd3;
    cyc("stall_cap");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 3'(6 - i);
      chan[3] = 8'hC0 + 8'(i);
      cyc("stall_hold");
    end
    out_ready = 1'b1; sel = 3'd5; chan[5] = 8'hE5;
    cyc("stall_rel");
    chan[3] = 8'h13; chan[5] = 8'h15;

    mode = 1'b1; req = 1'b0; ch_en = 8'b1010_0110;
    for (int i = 0; i < 7; i++) cyc("scan");
    check_val("scan.at5", 32'(out_ch), 32'd5);
    out_ready = 1'b0;
    cyc("scan_stall");
    cyc("scan_stall");
    out_ready = 1'b1;
    cyc("scan_after");
    check_val("scan.then7", 32'(out_ch), 32'd7);
    for (int i = 0; i < 3; i++) cyc("scan2");
    out_ready = 1'b0;
    cyc("scan2_stall");

    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid.out", 32'(out), 32'd0);
    check_val("rstmid.ch", 32'(out_ch), 32'd0);
    check_val("rstmid.last", 32'(out_last), 32'd0);
    check_val("rstmid.valid", 32'(out_valid), 32'd0);
    m_valid = 1'b0; m_ptr = 3'd0; sbq.delete();
    @(negedge clk);
    rst_n = 1'b1; ch_en = 8'hFF; out_ready = 1'b1;
    cyc("rst_first");
    check_val("rst_first.ch0", 32'(out_ch), 32'd0);
    cyc("rst_next");

    ch_en = 8'h00;
    cyc("empty");
    cyc("empty");
    ch_en = 8'h08;
    for (int i = 0; i < 3; i++) cyc("single");

    mode = 1'b0; req = 1'b0;
    cyc("drain");

    sel5 = 3'd6; req5 = 1'b1;
    @(posedge clk); #1;
    check_val("n5_oor.out", 32'(out5), 32'd0);
    check_val("n5_oor.ch", 32'(out_ch5), 32'd6);
    check_val("n5_oor.valid", 32'(out_valid5), 32'd1);
    check_val("n5_oor.err", 32'(sel_err5), 32'd1);
    sel5 = 3'd2;
    @(posedge clk); #1;
    check_val("n5_ok.err", 32'(sel_err5), 32'd0);
    check_val("n5_ok.out", 32'(out5), 32'h52);
    check_val("n5_ok.ch", 32'(out_ch5), 32'd2);
    req5 = 1'b0;
    @(posedge clk); #1;
    check_val("n5_idle.valid", 32'(out_valid5), 32'd0);
    mode5 = 1'b1; ch_en5 = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("n5_scan.ch", 32'(out_ch5), 32'(exp_ch5[i]));
      check_val("n5_scan.last", 32'(out_last5), 32'(i % 2));
      check_val("n5_scan.data", 32'(out5), 32'h50 + 32'(exp_ch5[i]));
      check_val("n5_scan.valid", 32'(out_valid5), 32'd1);
    end

    check_val("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
